vc_tagged_queue: RTL and testbench
==================================

VC_TAGGED_QUEUE -- requirements
Module: vc_tagged_queue

Interface
REQ-001 SHALL have parameter p_type, default 4'b0000, queue mode: bit0 = pipe, bit1 = bypass, both bits may be set.
REQ-002 SHALL have parameter p_msg_nbits, default 8, message payload width.
REQ-003 SHALL have parameter p_num_msgs, default 4, queue depth in entries; legal range 2..256, need not be a power of two.
REQ-004 SHALL have parameter p_afull_thresh, default 1, free-entry count at or below which almost_full asserts.
REQ-005 SHALL have port clk, input, 1, single clock; all state updates on posedge clk.
REQ-006 SHALL have port reset, input, 1, synchronous, active-high.
REQ-007 SHALL have port enq_val, input, 1, producer message valid.
REQ-008 SHALL have port enq_rdy, output, 1, queue can accept a message.
REQ-009 SHALL have port enq_msg, input, p_msg_nbits, enqueue payload.
REQ-010 SHALL have port enq_domain, input, 1, security domain tag of the enqueued message.
REQ-011 SHALL have port deq_val, output, 1, head message valid.
REQ-012 SHALL have port deq_rdy, input, 1, consumer ready.
REQ-013 SHALL have port deq_msg, output, p_msg_nbits, head payload.
REQ-014 SHALL have port deq_domain, output, 1, head domain tag.
REQ-015 SHALL have port flush, input, 1, scrub request: clears all entries.
REQ-016 SHALL have port num_free_entries, output, clog2(p_num_msgs)+1, free entry count.
REQ-017 SHALL have port almost_full, output, 1, asserted when num_free_entries <= p_afull_thresh.

Function
REQ-018 SHALL store payload and domain tag per entry in a circular buffer, using an enq pointer, a deq pointer and a full flag.
REQ-019 SHALL complete an enqueue only when enq_val && enq_rdy, and a dequeue only when deq_val && deq_rdy.
REQ-020 SHALL deassert enq_rdy only when full, except in pipe mode, where enq_rdy = ~full || deq_rdy.
REQ-021 SHALL assert deq_val only when non-empty, except in bypass mode, where deq_val = ~empty || enq_val.
REQ-022 SHALL, in bypass mode with the queue empty, drive deq_msg/deq_domain combinationally from enq_msg/enq_domain; a same-cycle enq+deq then writes nothing and moves no pointer.
REQ-023 SHALL, in pipe mode with the queue full, accept a same-cycle enq+deq: both pointers advance and full stays 1.
REQ-024 SHALL, for simultaneous enq+deq when neither full nor empty, advance both pointers and leave the occupancy unchanged.
REQ-025 SHALL wrap each pointer from p_num_msgs-1 to 0.
REQ-026 SHALL set full when an enq without a deq makes enq_ptr_next == deq_ptr, and clear full on any deq that is not a pipe.
REQ-027 SHALL drive deq_msg and deq_domain to all zeros whenever deq_val = 0, so no stale data is visible.
REQ-028 SHALL, when flush = 1 in a cycle:
- force enq_rdy = 0 and deq_val = 0 that cycle;
- on the clock edge, zero all payload and tag storage, both pointers and full.
REQ-029 SHALL give flush priority over any enq_val or deq_rdy in the same cycle; no transfer occurs.
REQ-030 SHALL have latency of 1 cycle from enqueue to deq_val in normal and pipe modes, and 0 cycles in bypass mode when empty.
REQ-031 SHALL compute num_free_entries from registered state only: p_num_msgs when empty, 0 when full, otherwise p_num_msgs - occupancy.
REQ-032 SHALL never overflow or underflow; enq_val while enq_rdy = 0 or deq_rdy while deq_val = 0 leaves state unchanged.

Reset
REQ-033 SHALL, on reset, clear pointers, full and all storage on the next posedge clk; reset overrides flush, enq and deq.
REQ-034 SHALL hold these output values during and after reset until the first transfer: enq_rdy = 1, deq_val = 0 (in bypass mode deq_val follows enq_val), deq_msg = 0, deq_domain = 0, num_free_entries = p_num_msgs, almost_full = (p_num_msgs <= p_afull_thresh).
REQ-035 SHALL abandon any in-flight contents when reset asserts mid-operation, with no transfer completing in that cycle.

Verification
REQ-036 SHALL be tested in normal mode, depth 4: enqueue 0x11/d0, 0x22/d1, 0x33/d0, 0x44/d1 -> enq_rdy = 0 and num_free_entries = 0; dequeue all four -> messages in order with matching tags; after the last, deq_msg = 0.
REQ-037 SHALL be tested in normal mode, depth 3, with 10 alternating enq/deq cycles -> pointers wrap, FIFO order holds, num_free_entries stays between 2 and 3.
REQ-038 SHALL be tested in pipe mode when full: enq 0x55 with deq_rdy = 1 -> enq_rdy = 1, head dequeued, 0x55 written, full remains 1.
REQ-039 SHALL be tested in bypass mode when empty: enq 0x7A/d1 with deq_rdy = 1 -> deq_msg = 0x7A and deq_domain = 1 in the same cycle; num_free_entries stays 4.
REQ-040 SHALL be tested with 3 entries queued, then flush = 1 together with enq_val = 1 -> no enqueue; next cycle deq_val = 0, deq_msg = 0, num_free_entries = 4; storage reads zero.
REQ-041 SHALL be tested with p_afull_thresh = 1 and depth 4: after 3 enqueues almost_full = 1; after 2 enqueues it = 0.

Source files
------------

// File: rtl/vc_tagged_queue.sv
// Circular-buffer message queue carrying a per-entry security-domain tag,
// with optional pipe/bypass behaviour and a scrubbing flush.
module vc_tagged_queue #(
  parameter logic [3:0]  p_type         = 4'b0000,
  parameter int unsigned p_msg_nbits    = 8,
  parameter int unsigned p_num_msgs     = 4,
  parameter int unsigned p_afull_thresh = 1
) (
  input  logic                         clk,
  input  logic                         reset,

  input  logic                         enq_val,
  output logic                         enq_rdy,
  input  logic [p_msg_nbits-1:0]       enq_msg,
  input  logic                         enq_domain,

  output logic                         deq_val,
  input  logic                         deq_rdy,
  output logic [p_msg_nbits-1:0]       deq_msg,
  output logic                         deq_domain,

  input  logic                         flush,
  output logic [$clog2(p_num_msgs):0]  num_free_entries,
  output logic                         almost_full
);

  localparam int unsigned c_addr_nbits = $clog2(p_num_msgs);
  localparam int unsigned c_cnt_nbits  = c_addr_nbits + 1;
  localparam logic [c_addr_nbits-1:0] c_last_idx = c_addr_nbits'(p_num_msgs - 1);
  localparam logic [c_cnt_nbits-1:0]  c_depth    = c_cnt_nbits'(p_num_msgs);
  localparam logic c_pipe   = p_type[0];
  localparam logic c_bypass = p_type[1];

  logic [p_msg_nbits-1:0]  mem_msg [p_num_msgs];
  logic                    mem_dom [p_num_msgs];
  logic [c_addr_nbits-1:0] enq_ptr;
  logic [c_addr_nbits-1:0] deq_ptr;
  logic                    full;

  logic                    empty_c;
  logic                    bypassing_c;
  logic                    do_enq_c;
  logic                    do_deq_c;
  logic                    wr_en_c;
  logic                    rd_en_c;
  logic [c_addr_nbits-1:0] enq_ptr_inc_c;
  logic [c_addr_nbits-1:0] deq_ptr_inc_c;
  logic                    full_next_c;
  logic [c_cnt_nbits-1:0]  occupancy_c;
  logic [c_cnt_nbits-1:0]  free_c;

  // Handshake, transfer qualification and output selection.
  always_comb begin
    empty_c       = 1'b0;
    bypassing_c   = 1'b0;
    enq_rdy       = 1'b0;
    deq_val       = 1'b0;
    do_enq_c      = 1'b0;
    do_deq_c      = 1'b0;
    wr_en_c       = 1'b0;
    rd_en_c       = 1'b0;
    enq_ptr_inc_c = '0;
    deq_ptr_inc_c = '0;
    full_next_c   = full;
    deq_msg       = '0;
    deq_domain    = 1'b0;
    occupancy_c   = '0;
    free_c        = '0;

    empty_c     = ~full && (enq_ptr == deq_ptr);
    bypassing_c = c_bypass && empty_c;

    enq_rdy = ~flush && (~full || (c_pipe && deq_rdy));
    deq_val = ~flush && (~empty_c || (c_bypass && enq_val));

    do_enq_c = enq_val && enq_rdy;
    do_deq_c = deq_val && deq_rdy;

    // A bypassed transfer goes straight through without touching storage.
    wr_en_c = do_enq_c && !(bypassing_c && do_deq_c);
    rd_en_c = do_deq_c && !bypassing_c;

    enq_ptr_inc_c = (enq_ptr == c_last_idx) ? '0 : enq_ptr + c_addr_nbits'(1);
    deq_ptr_inc_c = (deq_ptr == c_last_idx) ? '0 : deq_ptr + c_addr_nbits'(1);

    if (wr_en_c && !rd_en_c && (enq_ptr_inc_c == deq_ptr)) begin
      full_next_c = 1'b1;
    end else if (rd_en_c && !wr_en_c) begin
      full_next_c = 1'b0;
    end

    if (deq_val) begin
      if (bypassing_c) begin
        deq_msg    = enq_msg;
        deq_domain = enq_domain;
      end else begin
        deq_msg    = mem_msg[deq_ptr];
        deq_domain = mem_dom[deq_ptr];
      end
    end

    if (full) begin
      occupancy_c = c_depth;
    end else if (enq_ptr >= deq_ptr) begin
      occupancy_c = c_cnt_nbits'(enq_ptr) - c_cnt_nbits'(deq_ptr);
    end else begin
      occupancy_c = c_depth - c_cnt_nbits'(deq_ptr) + c_cnt_nbits'(enq_ptr);
    end

    free_c           = c_depth - occupancy_c;
    num_free_entries = free_c;
    almost_full      = (32'(free_c) <= p_afull_thresh);
  end

  // Storage and pointer state; flush scrubs contents like reset does.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      enq_ptr <= '0;
      deq_ptr <= '0;
      full    <= 1'b0;
      for (int i = 0; i < int'(p_num_msgs); i++) begin
        mem_msg[i] <= '0;
        mem_dom[i] <= 1'b0;
      end
    end else begin
      if (wr_en_c) begin
        mem_msg[enq_ptr] <= enq_msg;
        mem_dom[enq_ptr] <= enq_domain;
        enq_ptr          <= enq_ptr_inc_c;
      end
      if (rd_en_c) begin
        deq_ptr <= deq_ptr_inc_c;
      end
      full <= full_next_c;
    end
  end

endmodule

// File: tb/tb_vc_tagged_queue.sv
// Bench for vc_tagged_queue: four configurations checked every cycle against a
// list-based queue model, plus directed literal expectations.
module tb_vc_tagged_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       enq_val [4];
  logic       deq_rdy [4];
  logic       flush   [4];
  logic       enq_dom [4];
  logic [7:0] enq_msg [4];
  logic       enq_rdy [4];
  logic       deq_val [4];
  logic       deq_dom [4];
  logic       afull   [4];
  logic [7:0] deq_msg [4];
  logic [2:0] nfree   [4];

  // 0: normal depth 4, 1: normal depth 3, 2: pipe depth 4, 3: bypass depth 4
  vc_tagged_queue #(.p_type(4'b0000), .p_msg_nbits(8), .p_num_msgs(4), .p_afull_thresh(1)) u0 (
    .clk(clk), .reset(reset), .enq_val(enq_val[0]), .enq_rdy(enq_rdy[0]), .enq_msg(enq_msg[0]),
    .enq_domain(enq_dom[0]), .deq_val(deq_val[0]), .deq_rdy(deq_rdy[0]), .deq_msg(deq_msg[0]),
    .deq_domain(deq_dom[0]), .flush(flush[0]), .num_free_entries(nfree[0]), .almost_full(afull[0]));
  vc_tagged_queue #(.p_type(4'b0000), .p_msg_nbits(8), .p_num_msgs(3), .p_afull_thresh(1)) u1 (
    .clk(clk), .reset(reset), .enq_val(enq_val[1]), .enq_rdy(enq_rdy[1]), .enq_msg(enq_msg[1]),
    .enq_domain(enq_dom[1]), .deq_val(deq_val[1]), .deq_rdy(deq_rdy[1]), .deq_msg(deq_msg[1]),
    .deq_domain(deq_dom[1]), .flush(flush[1]), .num_free_entries(nfree[1]), .almost_full(afull[1]));
  vc_tagged_queue #(.p_type(4'b0001), .p_msg_nbits(8), .p_num_msgs(4), .p_afull_thresh(1)) u2 (
    .clk(clk), .reset(reset), .enq_val(enq_val[2]), .enq_rdy(enq_rdy[2]), .enq_msg(enq_msg[2]),
    .enq_domain(enq_dom[2]), .deq_val(deq_val[2]), .deq_rdy(deq_rdy[2]), .deq_msg(deq_msg[2]),
    .deq_domain(deq_dom[2]), .flush(flush[2]), .num_free_entries(nfree[2]), .almost_full(afull[2]));
  vc_tagged_queue #(.p_type(4'b0010), .p_msg_nbits(8), .p_num_msgs(4), .p_afull_thresh(1)) u3 (
    .clk(clk), .reset(reset), .enq_val(enq_val[3]), .enq_rdy(enq_rdy[3]), .enq_msg(enq_msg[3]),
    .enq_domain(enq_dom[3]), .deq_val(deq_val[3]), .deq_rdy(deq_rdy[3]), .deq_msg(deq_msg[3]),
    .deq_domain(deq_dom[3]), .flush(flush[3]), .num_free_entries(nfree[3]), .almost_full(afull[3]));

  int total = 0;
  int bad   = 0;
  bit started = 1'b0;

  // Model: ordered list of {domain, msg} with head at index 0.
  int         m_depth [4] = '{4, 3, 4, 4};
  bit         m_pipe  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  bit         m_byp   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic [8:0] m_buf   [4][4];
  int         m_cnt   [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic e_enq_rdy(input int i);
    return !flush[i] && ((m_cnt[i] != m_depth[i]) || (m_pipe[i] && deq_rdy[i]));
  endfunction

  function automatic logic e_deq_val(input int i);
    return !flush[i] && ((m_cnt[i] != 0) || (m_byp[i] && enq_val[i]));
  endfunction

  function automatic logic [8:0] e_head(input int i);
    if (!e_deq_val(i)) return 9'h0;
    if (m_cnt[i] == 0) return {enq_dom[i], enq_msg[i]};
    return m_buf[i][0];
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      started = 1'b1;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (flush[i]) begin
          m_cnt[i] = 0;
        end else begin
          automatic bit de = e_deq_val(i) && deq_rdy[i];
          automatic bit en = e_enq_rdy(i) && enq_val[i];
          if (!(m_cnt[i] == 0 && de)) begin
            if (de) begin
              for (int k = 0; k < 3; k++) m_buf[i][k] = m_buf[i][k+1];
              m_cnt[i]--;
            end
            if (en) begin
              m_buf[i][m_cnt[i]] = {enq_dom[i], enq_msg[i]};
              m_cnt[i]++;
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 4; i++) begin
        automatic logic [8:0] h  = e_head(i);
        automatic int         fr = m_depth[i] - m_cnt[i];
        chk($sformatf("enq_rdy[%0d]", i), 32'(enq_rdy[i]), 32'(e_enq_rdy(i)));
        chk($sformatf("deq_val[%0d]", i), 32'(deq_val[i]), 32'(e_deq_val(i)));
        chk($sformatf("deq_msg[%0d]", i), 32'(deq_msg[i]), 32'(h[7:0]));
        chk($sformatf("deq_dom[%0d]", i), 32'(deq_dom[i]), 32'(h[8]));
        chk($sformatf("nfree[%0d]", i), 32'(nfree[i]), 32'(fr));
        chk($sformatf("afull[%0d]", i), 32'(afull[i]), 32'(fr <= 1));
      end
    end
  end

  task automatic idle_all();
    for (int i = 0; i < 4; i++) begin
      enq_val[i] = 1'b0; deq_rdy[i] = 1'b0; flush[i] = 1'b0;
      enq_dom[i] = 1'b0; enq_msg[i] = 8'h00;
    end
  endtask

  task automatic drive(input int i, input logic ev, input logic [7:0] m, input logic d,
                       input logic dr, input logic fl);
    enq_val[i] = ev; enq_msg[i] = m; enq_dom[i] = d; deq_rdy[i] = dr; flush[i] = fl;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle_all();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  logic [7:0] t1m [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic       t1d [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [7:0] t3m [4] = '{8'h02, 8'h03, 8'h04, 8'h55};
  logic       t3d [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    reset = 1'b1;
    idle_all();
    step();
    step();
    settle();
    chk("reset_enq_rdy", 32'(enq_rdy[0]), 32'd1);
    chk("reset_deq_val", 32'(deq_val[0]), 32'd0);
    chk("reset_nfree", 32'(nfree[0]), 32'd4);
    chk("reset_afull", 32'(afull[0]), 32'd0);
    reset = 1'b0;
    step();

    // Fill normal depth-4 queue, check almost_full threshold, then drain in order.
    drive(0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0); step();
    drive(0, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0); step();
    settle();
    chk("afull_after2", 32'(afull[0]), 32'd0);
    chk("nfree_after2", 32'(nfree[0]), 32'd2);
    drive(0, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0); step();
    settle();
    chk("afull_after3", 32'(afull[0]), 32'd1);
    chk("nfree_after3", 32'(nfree[0]), 32'd1);
    drive(0, 1'b1, 8'h44, 1'b1, 1'b0, 1'b0); step();
    settle();
    chk("full_enq_rdy", 32'(enq_rdy[0]), 32'd0);
    chk("full_nfree", 32'(nfree[0]), 32'd0);
    drive(0, 1'b1, 8'h99, 1'b1, 1'b0, 1'b0);
    settle();
    chk("overflow_enq_rdy", 32'(enq_rdy[0]), 32'd0);
    step();
    for (int k = 0; k < 4; k++) begin
      drive(0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      settle();
      chk($sformatf("drain_val%0d", k), 32'(deq_val[0]), 32'd1);
      chk($sformatf("drain_msg%0d", k), 32'(deq_msg[0]), 32'(t1m[k]));
      chk($sformatf("drain_dom%0d", k), 32'(deq_dom[0]), 32'(t1d[k]));
      step();
    end
    settle();
    chk("empty_deq_val", 32'(deq_val[0]), 32'd0);
    chk("empty_deq_msg", 32'(deq_msg[0]), 32'd0);
    chk("empty_nfree", 32'(nfree[0]), 32'd4);
    drive(0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0); step();

    // Depth 3: alternating enq/deq across pointer wrap.
    for (int k = 0; k < 10; k++) begin
      if (k % 2 == 0) begin
        drive(1, 1'b1, 8'(32'hA0 + k), 1'((k / 2) % 2), 1'b0, 1'b0);
        settle();
        chk($sformatf("alt_nfree_e%0d", k), 32'(nfree[1]), 32'd3);
      end else begin
        drive(1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        settle();
        chk($sformatf("alt_nfree_d%0d", k), 32'(nfree[1]), 32'd2);
        chk($sformatf("alt_msg%0d", k), 32'(deq_msg[1]), 32'hA0 + 32'(k - 1));
        chk($sformatf("alt_dom%0d", k), 32'(deq_dom[1]), 32'(((k - 1) / 2) % 2));
      end
      step();
    end
    // Depth 3: simultaneous enq+deq with two entries resident.
    drive(1, 1'b1, 8'hB0, 1'b0, 1'b0, 1'b0); step();
    drive(1, 1'b1, 8'hB1, 1'b1, 1'b0, 1'b0); step();
    for (int k = 0; k < 5; k++) begin
      drive(1, 1'b1, 8'(32'hB2 + k), 1'(k % 2), 1'b1, 1'b0);
      settle();
      chk($sformatf("sim_msg%0d", k), 32'(deq_msg[1]), 32'hB0 + 32'(k));
      chk($sformatf("sim_nfree%0d", k), 32'(nfree[1]), 32'd1);
      step();
    end
    drive(1, 1'b1, 8'hC0, 1'b1, 1'b0, 1'b0); step();
    settle();
    chk("d3_full_nfree", 32'(nfree[1]), 32'd0);
    for (int k = 0; k < 3; k++) begin
      drive(1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0); step();
    end

    // Pipe mode: full queue accepts enq when the head leaves the same cycle.
    for (int k = 0; k < 4; k++) begin
      drive(2, 1'b1, 8'(k + 1), 1'(k % 2), 1'b0, 1'b0); step();
    end
    drive(2, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    settle();
    chk("pipe_full_no_deq", 32'(enq_rdy[2]), 32'd0);
    chk("pipe_full_nfree", 32'(nfree[2]), 32'd0);
    drive(2, 1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
    settle();
    chk("pipe_enq_rdy", 32'(enq_rdy[2]), 32'd1);
    chk("pipe_head_msg", 32'(deq_msg[2]), 32'h01);
    chk("pipe_head_dom", 32'(deq_dom[2]), 32'd0);
    step();
    settle();
    chk("pipe_still_full", 32'(nfree[2]), 32'd0);
    for (int k = 0; k < 4; k++) begin
      drive(2, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      settle();
      chk($sformatf("pipe_drain_msg%0d", k), 32'(deq_msg[2]), 32'(t3m[k]));
      chk($sformatf("pipe_drain_dom%0d", k), 32'(deq_dom[2]), 32'(t3d[k]));
      step();
    end

    // Bypass mode: empty queue forwards enq payload combinationally.
    drive(3, 1'b1, 8'h7A, 1'b1, 1'b1, 1'b0);
    settle();
    chk("byp_val", 32'(deq_val[3]), 32'd1);
    chk("byp_msg", 32'(deq_msg[3]), 32'h7A);
    chk("byp_dom", 32'(deq_dom[3]), 32'd1);
    chk("byp_nfree", 32'(nfree[3]), 32'd4);
    step();
    settle();
    chk("byp_after_nfree", 32'(nfree[3]), 32'd4);
    chk("byp_after_val", 32'(deq_val[3]), 32'd0);
    drive(3, 1'b1, 8'h66, 1'b0, 1'b0, 1'b0);
    settle();
    chk("byp_stall_msg", 32'(deq_msg[3]), 32'h66);
    step();
    settle();
    chk("byp_stored_nfree", 32'(nfree[3]), 32'd3);
    drive(3, 1'b1, 8'h13, 1'b1, 1'b1, 1'b0);
    settle();
    chk("byp_nonempty_msg", 32'(deq_msg[3]), 32'h66);
    step();
    settle();
    chk("byp_next_msg", 32'(deq_msg[3]), 32'h13);
    drive(3, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0); step();

    // Flush with three entries and a competing enqueue.
    drive(0, 1'b1, 8'h31, 1'b0, 1'b0, 1'b0); step();
    drive(0, 1'b1, 8'h32, 1'b1, 1'b0, 1'b0); step();
    drive(0, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0); step();
    drive(0, 1'b1, 8'h34, 1'b1, 1'b1, 1'b1);
    settle();
    chk("flush_enq_rdy", 32'(enq_rdy[0]), 32'd0);
    chk("flush_deq_val", 32'(deq_val[0]), 32'd0);
    chk("flush_deq_msg", 32'(deq_msg[0]), 32'd0);
    step();
    settle();
    chk("post_flush_val", 32'(deq_val[0]), 32'd0);
    chk("post_flush_msg", 32'(deq_msg[0]), 32'd0);
    chk("post_flush_nfree", 32'(nfree[0]), 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("scrub_msg%0d", k), 32'(u0.mem_msg[k]), 32'd0);
      chk($sformatf("scrub_dom%0d", k), 32'(u0.mem_dom[k]), 32'd0);
    end
    drive(0, 1'b1, 8'h77, 1'b1, 1'b0, 1'b0); step();
    settle();
    chk("post_flush_enq_msg", 32'(deq_msg[0]), 32'h77);
    chk("post_flush_enq_dom", 32'(deq_dom[0]), 32'd1);
    drive(0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0); step();

    // Reset in mid-operation abandons contents and blocks the pending transfer.
    drive(2, 1'b1, 8'h81, 1'b0, 1'b0, 1'b0); step();
    drive(2, 1'b1, 8'h82, 1'b1, 1'b0, 1'b0);
    drive(1, 1'b1, 8'h91, 1'b1, 1'b0, 1'b0); step();
    reset = 1'b1;
    drive(2, 1'b1, 8'h88, 1'b0, 1'b1, 1'b0);
    step();
    settle();
    chk("rst_mid_nfree2", 32'(nfree[2]), 32'd4);
    chk("rst_mid_enq_rdy", 32'(enq_rdy[2]), 32'd1);
    chk("rst_mid_deq_val", 32'(deq_val[2]), 32'd0);
    chk("rst_mid_nfree1", 32'(nfree[1]), 32'd3);
    step();
    reset = 1'b0;
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
